// File: rtl/branch_redirect_unit_pkg.sv
// branch_redirect_unit_pkg: shared opcode/funct3 constants and FSM state type
package branch_redirect_unit_pkg;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [2:0] FUNCT3_BEQ    = 3'b000;
  localparam logic [2:0] FUNCT3_BNE    = 3'b001;
  localparam logic [2:0] FUNCT3_BLT    = 3'b100;
  localparam logic [2:0] FUNCT3_BGE    = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU   = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU   = 3'b111;
  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;
endpackage

// File: rtl/branch_redirect_unit_sat_counter.sv
// sat_counter: increment-enable counter that sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);
  always_ff @(posedge clk or posedge reset)
    if (reset) count_o <= '0;
    else if (inc_i && !(&count_o)) count_o <= count_o + 1'b1;
endmodule

// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit: resolves EX-stage branches/jumps, issues fetch redirects and flush windows
module branch_redirect_unit
  import branch_redirect_unit_pkg::*;
#(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_i,
  input  logic [6:0]           opcode_i,
  input  logic [2:0]           funct3_i,
  input  logic [AWIDTH-1:0]    pc_i,
  input  logic [DWIDTH-1:0]    imm_i,
  input  logic [DWIDTH-1:0]    rs1_i,
  input  logic                 breq_i,
  input  logic                 brlt_i,
  input  logic                 redir_ready_i,
  output logic                 redir_valid_o,
  output logic [AWIDTH-1:0]    redir_pc_o,
  output logic                 flush_o,
  output logic                 stall_o,
  output logic [CNT_WIDTH-1:0] br_count_o,
  output logic [CNT_WIDTH-1:0] taken_count_o
);
  localparam int FW = $clog2(FLUSH_CYCLES + 2);
  state_t state, state_n;
  logic [FW-1:0] cnt, cnt_n;
  logic eval, is_cond, cond_taken, is_jal, is_jalr, taken, need_redir;
  logic [AWIDTH-1:0] jalr_sum, target;
  assign eval = valid_i && state == IDLE;
  // funct3 010/011 are reserved branch encodings and are ignored entirely
  assign is_cond = opcode_i == OPCODE_BRANCH && funct3_i[2:1] != 2'b01;
  assign cond_taken = funct3_i[2] ? brlt_i ^ funct3_i[0] : breq_i ^ funct3_i[0];
  assign is_jal = opcode_i == OPCODE_JAL;
  assign is_jalr = opcode_i == OPCODE_JALR;
  assign taken = (is_cond && cond_taken) || is_jal || is_jalr;
  assign jalr_sum = AWIDTH'(rs1_i + imm_i);
  assign target = is_jalr ? {jalr_sum[AWIDTH-1:1], 1'b0} : pc_i + AWIDTH'(imm_i);
  assign need_redir = eval && taken && target != pc_i + AWIDTH'(4);
  assign redir_valid_o = state == REDIRECT;
  assign flush_o = state != IDLE;
  assign stall_o = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    unique case (state)
      IDLE: state_n = need_redir ? REDIRECT : IDLE;
      REDIRECT: if (redir_ready_i) begin
        state_n = FLUSH_CYCLES == 0 ? IDLE : FLUSH;
        cnt_n = FW'(FLUSH_CYCLES);
      end
      FLUSH: begin
        cnt_n = cnt - 1'b1;
        state_n = cnt == FW'(1) ? IDLE : FLUSH;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      redir_pc_o <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (need_redir) redir_pc_o <= target;
    end
  sat_counter #(.WIDTH(CNT_WIDTH)) u_br_cnt (
    .clk(clk), .reset(reset), .inc_i(eval && is_cond), .count_o(br_count_o)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_taken_cnt (
    .clk(clk), .reset(reset), .inc_i(eval && is_cond && cond_taken), .count_o(taken_count_o)
  );
endmodule

// File: tb/tb_branch_redirect_unit.sv
// tb_branch_redirect_unit: directed checks of redirect timing, decisions and counters
module tb_branch_redirect_unit;
  import branch_redirect_unit_pkg::*;
  logic clk = 0, reset = 1, valid_i = 0, breq_i = 0, brlt_i = 0, redir_ready_i = 0;
  logic [6:0] opcode_i = '0;
  logic [2:0] funct3_i = '0;
  logic [31:0] pc_i = '0, imm_i = '0, rs1_i = '0;
  logic redir_valid_o, flush_o, stall_o;
  logic [31:0] redir_pc_o, br_count_o, taken_count_o;
  logic redir_valid4, flush4, stall4;
  logic [31:0] redir_pc4;
  logic [3:0] br4, taken4;
  int checks = 0, errors = 0;

  branch_redirect_unit dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .opcode_i(opcode_i), .funct3_i(funct3_i),
    .pc_i(pc_i), .imm_i(imm_i), .rs1_i(rs1_i), .breq_i(breq_i), .brlt_i(brlt_i),
    .redir_ready_i(redir_ready_i), .redir_valid_o(redir_valid_o), .redir_pc_o(redir_pc_o),
    .flush_o(flush_o), .stall_o(stall_o), .br_count_o(br_count_o), .taken_count_o(taken_count_o)
  );
  branch_redirect_unit #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .valid_i(valid_i), .opcode_i(opcode_i), .funct3_i(funct3_i),
    .pc_i(pc_i), .imm_i(imm_i), .rs1_i(rs1_i), .breq_i(breq_i), .brlt_i(brlt_i),
    .redir_ready_i(redir_ready_i), .redir_valid_o(redir_valid4), .redir_pc_o(redir_pc4),
    .flush_o(flush4), .stall_o(stall4), .br_count_o(br4), .taken_count_o(taken4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] rs1, input logic eq, input logic lt);
    valid_i = 1; opcode_i = op; funct3_i = f3; pc_i = pc; imm_i = imm; rs1_i = rs1;
    breq_i = eq; brlt_i = lt;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({redir_valid_o, flush_o, stall_o, redir_pc_o} !== 35'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {redir_valid_o, flush_o, stall_o, redir_pc_o});
    end
    checks++;
    if ({br_count_o, taken_count_o} !== 64'd0) begin
      errors++; $display("FAIL reset_counters: got %h expected 0", {br_count_o, taken_count_o});
    end
    reset = 0;
    tick();
  endtask

  task automatic test_beq_redirect();
    redir_ready_i = 1;
    drive(OPCODE_BRANCH, FUNCT3_BEQ, 32'h100, 32'h20, 0, 1, 0);
    tick();
    valid_i = 0;
    checks++;
    if ({redir_valid_o, flush_o, stall_o} !== 3'b111 || redir_pc_o !== 32'h120) begin
      errors++; $display("FAIL beq_n1: got vfs=%b pc=%h expected vfs=111 pc=120", {redir_valid_o, flush_o, stall_o}, redir_pc_o);
    end
    checks++;
    if (br_count_o !== 1 || taken_count_o !== 1) begin
      errors++; $display("FAIL beq_counts: got %0d/%0d expected 1/1", br_count_o, taken_count_o);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({redir_valid_o, flush_o, stall_o} !== 3'b011) begin
        errors++; $display("FAIL beq_flush%0d: got vfs=%b expected 011", i, {redir_valid_o, flush_o, stall_o});
      end
    end
    tick();
    checks++;
    if ({redir_valid_o, flush_o, stall_o} !== 3'b000) begin
      errors++; $display("FAIL beq_idle: got vfs=%b expected 000", {redir_valid_o, flush_o, stall_o});
    end
  endtask

  task automatic test_no_redirect();
    drive(OPCODE_BRANCH, FUNCT3_BLT, 32'h200, 32'h40, 0, 0, 0);
    tick();
    drive(OPCODE_BRANCH, FUNCT3_BGEU, 32'h204, 32'h4, 0, 0, 0);
    checks++;
    if ({redir_valid_o, flush_o, stall_o} !== 3'b000) begin
      errors++; $display("FAIL blt_not_taken: got vfs=%b expected 000", {redir_valid_o, flush_o, stall_o});
    end
    tick();
    drive(OPCODE_BRANCH, 3'b010, 32'h208, 32'h80, 0, 1, 1);
    checks++;
    if ({redir_valid_o, flush_o, stall_o} !== 3'b000 || br_count_o !== 3 || taken_count_o !== 2) begin
      errors++; $display("FAIL bgeu_pc4: got vfs=%b cnt=%0d/%0d expected 000 3/2", {redir_valid_o, flush_o, stall_o}, br_count_o, taken_count_o);
    end
    tick();
    valid_i = 0;
    checks++;
    if ({redir_valid_o, flush_o} !== 2'b00 || br_count_o !== 3 || taken_count_o !== 2) begin
      errors++; $display("FAIL illegal_f3: got vf=%b cnt=%0d/%0d expected 00 3/2", {redir_valid_o, flush_o}, br_count_o, taken_count_o);
    end
  endtask

  task automatic test_jalr_backpressure();
    redir_ready_i = 0;
    drive(OPCODE_JALR, 3'b000, 32'h300, 32'h10, 32'h1001, 0, 0);
    tick();
    valid_i = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (redir_valid_o !== 1 || redir_pc_o !== 32'h1010) begin
        errors++; $display("FAIL jalr_hold%0d: got v=%b pc=%h expected v=1 pc=1010", i, redir_valid_o, redir_pc_o);
      end
      if (i < 3) tick();
    end
    redir_ready_i = 1;
    tick();
    checks++;
    if ({redir_valid_o, flush_o} !== 2'b01 || br_count_o !== 3 || taken_count_o !== 2) begin
      errors++; $display("FAIL jalr_after_hs: got vf=%b cnt=%0d/%0d expected 01 3/2", {redir_valid_o, flush_o}, br_count_o, taken_count_o);
    end
    tick(); tick();
  endtask

  task automatic test_jal_wrap();
    redir_ready_i = 0;
    drive(OPCODE_JAL, 3'b000, 32'hFFFF_FFF8, 32'h10, 0, 0, 0);
    tick();
    checks++;
    if (redir_valid_o !== 1 || redir_pc_o !== 32'h8) begin
      errors++; $display("FAIL jal_wrap: got v=%b pc=%h expected v=1 pc=00000008", redir_valid_o, redir_pc_o);
    end
    drive(OPCODE_BRANCH, FUNCT3_BEQ, 32'h400, 32'h80, 0, 1, 0);
    tick();
    redir_ready_i = 1;
    tick();
    tick();
    valid_i = 0;
    tick();
    checks++;
    if ({redir_valid_o, flush_o} !== 2'b00 || redir_pc_o !== 32'h8 || br_count_o !== 3 || taken_count_o !== 2) begin
      errors++; $display("FAIL wrong_path_ignored: got vf=%b pc=%h cnt=%0d/%0d expected 00 8 3/2", {redir_valid_o, flush_o}, redir_pc_o, br_count_o, taken_count_o);
    end
  endtask

  task automatic test_reset_mid();
    redir_ready_i = 0;
    drive(OPCODE_BRANCH, FUNCT3_BNE, 32'h500, 32'h100, 0, 0, 0);
    tick();
    valid_i = 0;
    checks++;
    if (redir_valid_o !== 1 || redir_pc_o !== 32'h600) begin
      errors++; $display("FAIL bne_pre_reset: got v=%b pc=%h expected v=1 pc=600", redir_valid_o, redir_pc_o);
    end
    reset = 1;
    tick();
    checks++;
    if ({redir_valid_o, flush_o, stall_o, redir_pc_o, br_count_o, taken_count_o} !== 99'd0) begin
      errors++; $display("FAIL mid_reset: got vfs=%b pc=%h cnt=%0d/%0d expected all 0", {redir_valid_o, flush_o, stall_o}, redir_pc_o, br_count_o, taken_count_o);
    end
    reset = 0;
    redir_ready_i = 1;
    drive(OPCODE_BRANCH, FUNCT3_BNE, 32'h500, 32'hFFFF_FFF8, 0, 0, 0);
    tick();
    valid_i = 0;
    checks++;
    if ({redir_valid_o, flush_o, stall_o} !== 3'b111 || redir_pc_o !== 32'h4F8 || br_count_o !== 1 || taken_count_o !== 1) begin
      errors++; $display("FAIL bne_after_reset: got vfs=%b pc=%h cnt=%0d/%0d expected 111 4f8 1/1", {redir_valid_o, flush_o, stall_o}, redir_pc_o, br_count_o, taken_count_o);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_back_to_back();
    redir_ready_i = 1;
    drive(OPCODE_BRANCH, FUNCT3_BEQ, 32'h700, 32'h10, 0, 1, 0);
    tick();
    valid_i = 0;
    tick(); tick();
    drive(OPCODE_JAL, 3'b000, 32'h800, 32'h40, 0, 0, 0);
    tick();
    checks++;
    if (flush_o !== 0) begin
      errors++; $display("FAIL b2b_idle: got flush=%b expected 0", flush_o);
    end
    tick();
    valid_i = 0;
    checks++;
    if (redir_valid_o !== 1 || redir_pc_o !== 32'h840 || br_count_o !== 2 || taken_count_o !== 2) begin
      errors++; $display("FAIL b2b_jal: got v=%b pc=%h cnt=%0d/%0d expected 1 840 2/2", redir_valid_o, redir_pc_o, br_count_o, taken_count_o);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_saturate();
    drive(OPCODE_BRANCH, FUNCT3_BEQ, 32'h900, 32'h40, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (br4 !== 4'hF || taken4 !== 4'd2 || br_count_o !== 22 || flush_o !== 0) begin
      errors++; $display("FAIL br_saturate: got br4=%h taken4=%h br=%0d flush=%b expected f 2 22 0", br4, taken4, br_count_o, flush_o);
    end
    drive(OPCODE_BRANCH, FUNCT3_BGE, 32'h900, 32'h4, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    valid_i = 0;
    checks++;
    if (br4 !== 4'hF || taken4 !== 4'hF || taken_count_o !== 22 || br_count_o !== 42) begin
      errors++; $display("FAIL taken_saturate: got br4=%h taken4=%h cnt=%0d/%0d expected f f 42/22", br4, taken4, br_count_o, taken_count_o);
    end
  endtask

  initial begin
    test_reset();
    test_beq_redirect();
    test_no_redirect();
    test_jalr_backpressure();
    test_jal_wrap();
    test_reset_mid();
    test_back_to_back();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
